// File: rtl/pio_mem_bram_ro_if.sv
// PIO register bus bundle for the application-written, PIO-read status memory.
interface pio_mem_bram_ro_if #(
    parameter int PIO_NBITS = 32
);
    logic [PIO_NBITS-1:0] reg_addr;
    logic [PIO_NBITS-1:0] reg_din;
    logic                 reg_rd;
    logic                 reg_wr;
    logic                 reg_ms;
    logic                 mem_ack;
    logic [PIO_NBITS-1:0] mem_rdata;
    logic                 pio_wr_ignored;
    logic                 pio_req_drop;

    modport master (
        output reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        input  mem_ack, mem_rdata, pio_wr_ignored, pio_req_drop
    );

    modport slave (
        input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        output mem_ack, mem_rdata, pio_wr_ignored, pio_req_drop
    );
endinterface

// File: rtl/pio_mem_bram_ro.sv
// Application-written, PIO-readable status memory with optional clear-on-read.
// The application write port always wins; a pending clear uses the first idle write slot.
module pio_mem_bram_ro #(
    parameter int WIDTH       = 20,
    parameter int DEPTH_NBITS = 1,
    parameter int CLR_ON_RD   = 0,
    parameter int PIO_NBITS   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_div,
    pio_mem_bram_ro_if.slave       pio,
    input  logic                   app_mem_wr,
    input  logic [DEPTH_NBITS-1:0] app_mem_waddr,
    input  logic [WIDTH-1:0]       app_mem_wdata
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_ACKW = 3'd3,
        S_ACKH = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DEPTH_NBITS-1:0] idx_q, idx_d;
    logic [DEPTH_NBITS-1:0] clr_idx_q, clr_idx_d;
    logic                   clr_pend_q, clr_pend_d;
    logic                   cancel_q, cancel_d;
    logic                   ack_q, ack_d;
    logic [PIO_NBITS-1:0]   rdata_q, rdata_d;
    logic                   wr_ign_q, wr_ign_d;
    logic                   drop_q, drop_d;

    logic [WIDTH-1:0]       mem [2**DEPTH_NBITS];
    logic [WIDTH-1:0]       ram_rdata;
    logic                   ram_we;
    logic [DEPTH_NBITS-1:0] ram_waddr;
    logic [WIDTH-1:0]       ram_wdata;

    logic req, clr_fire, app_hit_idx, app_hit_clr;
    logic unused_pio;

    assign unused_pio  = ^{pio.reg_din, pio.reg_addr};
    assign req         = pio.reg_ms & (pio.reg_rd | pio.reg_wr);
    assign clr_fire    = clr_pend_q & ~app_mem_wr;
    assign app_hit_idx = app_mem_wr && (app_mem_waddr == idx_q);
    assign app_hit_clr = app_mem_wr && (app_mem_waddr == clr_idx_q);

    assign ram_we    = app_mem_wr | clr_fire;
    assign ram_waddr = app_mem_wr ? app_mem_waddr : clr_idx_q;
    assign ram_wdata = app_mem_wr ? app_mem_wdata : '0;

    // Read address is the latched index every cycle; the value sampled during RD is used.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[idx_q];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_idx_d  = clr_idx_q;
        clr_pend_d = clr_pend_q;
        cancel_d   = cancel_q;
        ack_d      = ack_q;
        rdata_d    = rdata_q;
        wr_ign_d   = 1'b0;
        drop_d     = req && (state_q != S_IDLE);

        // Either the clear lands this cycle or an app write to that entry supersedes it.
        if (clr_pend_q && (clr_fire || app_hit_clr))
            clr_pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d    = pio.reg_addr[2 +: DEPTH_NBITS];
                    cancel_d = 1'b0;
                    if (pio.reg_rd) begin
                        state_d = S_RD;
                    end else begin
                        state_d  = S_ACKW;
                        wr_ign_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                // An older clear must land first so this read sees post-clear data.
                if (!clr_pend_q) begin
                    cancel_d = app_hit_idx;
                    state_d  = S_CAP;
                end
            end
            S_CAP: begin
                rdata_d = PIO_NBITS'(ram_rdata);
                if ((CLR_ON_RD != 0) && !cancel_q && !app_hit_idx) begin
                    clr_pend_d = 1'b1;
                    clr_idx_d  = idx_q;
                end
                state_d = S_ACKW;
            end
            S_ACKW: begin
                if (clk_div) begin
                    ack_d   = 1'b1;
                    state_d = S_ACKH;
                end
            end
            S_ACKH: begin
                if (clk_div) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            clr_idx_q  <= '0;
            clr_pend_q <= 1'b0;
            cancel_q   <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            wr_ign_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_idx_q  <= clr_idx_d;
            clr_pend_q <= clr_pend_d;
            cancel_q   <= cancel_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            wr_ign_q   <= wr_ign_d;
            drop_q     <= drop_d;
        end
    end

    assign pio.mem_ack        = ack_q;
    assign pio.mem_rdata      = rdata_q;
    assign pio.pio_wr_ignored = wr_ign_q;
    assign pio.pio_req_drop   = drop_q;
endmodule

// File: tb/tb_pio_mem_bram_ro.sv
// Directed scoreboard bench: one instance without and one with clear-on-read.
module tb_pio_mem_bram_ro;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_div;
    logic [1:0]  dcnt = 2'd0;

    logic        app_wr0 = 1'b0, app_wr1 = 1'b0;
    logic [0:0]  app_a0 = '0, app_a1 = '0;
    logic [19:0] app_d0 = '0, app_d1 = '0;

    int total = 0;
    int fails = 0;
    logic [31:0] sb[$];

    pio_mem_bram_ro_if #(.PIO_NBITS(32)) p0 ();
    pio_mem_bram_ro_if #(.PIO_NBITS(32)) p1 ();

    pio_mem_bram_ro #(.WIDTH(20), .DEPTH_NBITS(1), .CLR_ON_RD(0), .PIO_NBITS(32)) u0 (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .pio(p0),
        .app_mem_wr(app_wr0), .app_mem_waddr(app_a0), .app_mem_wdata(app_d0)
    );

    pio_mem_bram_ro #(.WIDTH(20), .DEPTH_NBITS(1), .CLR_ON_RD(1), .PIO_NBITS(32)) u1 (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .pio(p1),
        .app_mem_wr(app_wr1), .app_mem_waddr(app_a1), .app_mem_wdata(app_d1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) dcnt <= dcnt + 2'd1;
    assign clk_div = (dcnt == 2'd3);

    function automatic logic get_ack(input int d);
        return (d != 0) ? p1.mem_ack : p0.mem_ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d != 0) ? p1.mem_rdata : p0.mem_rdata;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pio(input int d, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] dat);
        if (d != 0) begin
            p1.reg_rd = rd; p1.reg_wr = wr; p1.reg_ms = rd | wr; p1.reg_addr = a; p1.reg_din = dat;
        end else begin
            p0.reg_rd = rd; p0.reg_wr = wr; p0.reg_ms = rd | wr; p0.reg_addr = a; p0.reg_din = dat;
        end
    endtask

    task automatic pio_req(input int d, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] dat);
        set_pio(d, rd, wr, a, dat);
        @(posedge clk); #1;
        set_pio(d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic app_write(input int d, input logic [0:0] a, input logic [19:0] v);
        if (d != 0) begin app_wr1 = 1'b1; app_a1 = a; app_d1 = v; end
        else        begin app_wr0 = 1'b1; app_a0 = a; app_d0 = v; end
        @(posedge clk); #1;
        if (d != 0) app_wr1 = 1'b0; else app_wr0 = 1'b0;
    endtask

    // Bounded wait for ack rise; reports whether it rose.
    task automatic wait_rise(input int d, input string tag, output logic got);
        int n = 0;
        got = 1'b0;
        while (n < 64 && !got) begin
            @(negedge clk);
            got = get_ack(d);
            n++;
        end
        check({tag, "_ack_rise"}, 32'(got), 32'd1);
    endtask

    // Counts ack-high cycles (starting at a negedge where ack is high) until it falls.
    task automatic wait_fall(input int d, output int width);
        width = 1;
        @(negedge clk);
        while (get_ack(d) && width < 64) begin
            width++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic pio_read(input int d, input string tag, input logic [31:0] a,
                            input logic [31:0] exp, output int width);
        logic got;
        logic [31:0] e;
        sb.push_back(exp);
        pio_req(d, 1'b1, 1'b0, a, '0);
        wait_rise(d, tag, got);
        e = sb.pop_front();
        check(tag, get_rdata(d), e);
        width = 0;
        if (got) wait_fall(d, width);
    endtask

    initial begin
        int w;
        logic got;
        logic [31:0] e;
        int extra;

        set_pio(0, 1'b0, 1'b0, '0, '0);
        set_pio(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0",   32'(p0.mem_ack), 32'd0);
        check("rst_rdata0", p0.mem_rdata, 32'd0);
        check("rst_wign0",  32'(p0.pio_wr_ignored), 32'd0);
        check("rst_drop0",  32'(p0.pio_req_drop), 32'd0);
        check("rst_ack1",   32'(p1.mem_ack), 32'd0);
        check("rst_rdata1", p1.mem_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain read, ack width, and aliasing of upper index bits
        app_write(0, 1'b1, 20'hABCDE);
        pio_read(0, "t1_read", 32'h4, 32'h000ABCDE, w);
        check("t1_ack_width", 32'(w), 32'd4);
        pio_read(0, "t1_reread", 32'h4, 32'h000ABCDE, w);
        pio_read(0, "t1_alias", 32'hC, 32'h000ABCDE, w);

        // Clear-on-read
        app_write(1, 1'b0, 20'h12345);
        pio_read(1, "t2_first", 32'h0, 32'h00012345, w);
        pio_read(1, "t2_second", 32'h0, 32'h00000000, w);

        // Clear deferred while app port is busy on another address
        app_write(1, 1'b0, 20'h11111);
        fork
            pio_read(1, "t3_read", 32'h0, 32'h00011111, w);
            begin
                for (int unsigned i = 0; i < 6; i++) begin
                    @(posedge clk); #1;
                    app_wr1 = 1'b1; app_a1 = 1'b1; app_d1 = 20'h20000 + 20'(i);
                end
                @(negedge clk);
                check("t3_pend_held", 32'(u1.clr_pend_q), 32'd1);
                @(posedge clk); #1;
                app_wr1 = 1'b0;
                @(negedge clk);
                check("t3_pend_before", 32'(u1.clr_pend_q), 32'd1);
                @(negedge clk);
                check("t3_pend_done", 32'(u1.clr_pend_q), 32'd0);
            end
        join
        pio_read(1, "t3_addr0", 32'h0, 32'h00000000, w);
        pio_read(1, "t3_addr1", 32'h4, 32'h00020005, w);

        // App write in CAP cycle cancels the clear
        app_write(1, 1'b0, 20'h33333);
        fork
            pio_read(1, "t4_old", 32'h0, 32'h00033333, w);
            begin
                @(posedge clk);
                @(posedge clk); #1;
                app_wr1 = 1'b1; app_a1 = 1'b0; app_d1 = 20'h55555;
                @(posedge clk); #1;
                app_wr1 = 1'b0;
            end
        join
        pio_read(1, "t4_new", 32'h0, 32'h00055555, w);
        pio_read(1, "t4_cleared", 32'h0, 32'h00000000, w);

        // PIO write is acknowledged and discarded
        app_write(0, 1'b0, 20'h0BEEF);
        pio_req(0, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        check("t5_wign_pulse", 32'(p0.pio_wr_ignored), 32'd1);
        @(negedge clk);
        check("t5_wign_once", 32'(p0.pio_wr_ignored), 32'd0);
        wait_rise(0, "t5_wr", got);
        if (got) wait_fall(0, w);
        pio_read(0, "t5_prior", 32'h0, 32'h0000BEEF, w);

        // Request while busy is dropped and produces no extra ack
        sb.push_back(32'h000ABCDE);
        pio_req(0, 1'b1, 1'b0, 32'h4, '0);
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_in_ackw", 32'(u0.state_q), 32'd3);
        set_pio(0, 1'b1, 1'b0, 32'h0, '0);
        @(posedge clk); #1;
        set_pio(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("t6_drop_pulse", 32'(p0.pio_req_drop), 32'd1);
        wait_rise(0, "t6", got);
        e = sb.pop_front();
        check("t6_rdata", p0.mem_rdata, e);
        if (got) wait_fall(0, w);
        extra = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p0.mem_ack) extra++;
        end
        check("t6_no_second_ack", 32'(extra), 32'd0);

        // Asynchronous reset while ack is high
        @(posedge clk); #1;
        sb.push_back(32'h000ABCDE);
        pio_req(0, 1'b1, 1'b0, 32'h4, '0);
        wait_rise(0, "t6r", got);
        e = sb.pop_front();
        check("t6r_rdata", p0.mem_rdata, e);
        #2 rst_n = 1'b0;
        #1;
        check("t6r_ack_async", 32'(p0.mem_ack), 32'd0);
        check("t6r_state_idle", 32'(u0.state_q), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pio_read(0, "t6r_after", 32'h4, 32'h000ABCDE, w);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
